// File: rtl/core_led_scheduler.sv
// Four-core job status scheduler. Each core runs a small IDLE/RUN/DONE
// state machine driven by start/done strobes. Running cores blink their
// LED from a shared prescaler, finished cores light steadily, and a
// saturating counter tallies completed jobs.
module core_led_scheduler #(
  parameter int BLINK_HALF = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] core_start,
  input  logic [3:0] core_done,
  input  logic       clear,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic       led4,
  output logic       led_done,
  output logic [7:0] done_cnt
);

  // Width of the prescaler; a 1-bit counter still covers BLINK_HALF = 2.
  localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } core_state_t;

  logic [PW-1:0] presc_reg;
  logic [PW-1:0] presc_next;
  logic          phase_reg;
  logic          phase_next;
  logic [7:0]    cnt_reg;
  logic [7:0]    cnt_next;

  logic [3:0]    led_vec;
  logic [3:0]    done_vec;
  logic [3:0]    fin_vec;

  // Prescaler and blink phase: free-running, untouched by clear or core inputs.
  always_comb begin
    presc_next = presc_reg + PW'(1);
    phase_next = phase_reg;
    if (presc_reg == PRESC_LAST) begin
      presc_next = '0;
      phase_next = ~phase_reg;
    end
  end

  // Prescaler and blink phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      phase_reg <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      phase_reg <= phase_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_core
      core_state_t state_reg;
      core_state_t state_next;
      logic        fin;

      // Next-state logic; clear dominates every strobe, and fin flags a RUN->DONE step.
      always_comb begin
        state_next = state_reg;
        fin        = 1'b0;
        if (clear) begin
          state_next = IDLE;
        end else begin
          case (state_reg)
            IDLE: if (core_start[gi]) state_next = RUN;
            RUN: begin
              if (core_done[gi]) begin
                state_next = DONE;
                fin        = 1'b1;
              end
            end
            DONE: if (core_start[gi]) state_next = RUN;
            default: state_next = IDLE;
          endcase
        end
      end

      // Per-core state register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= IDLE;
        end else begin
          state_reg <= state_next;
        end
      end

      // LED decode straight from registered state so reset blanks it at once.
      assign led_vec[gi]  = (state_reg == DONE) ? 1'b1 :
                            (state_reg == RUN)  ? phase_reg : 1'b0;
      assign done_vec[gi] = (state_reg == DONE);
      assign fin_vec[gi]  = fin;
    end
  endgenerate

  // Completion counter: add this edge's finishes, clamp at 255, clear wins.
  always_comb begin
    logic [2:0] inc;
    logic [8:0] sum;
    inc = 3'd0;
    for (int i = 0; i < 4; i++) begin
      inc = inc + {2'b00, fin_vec[i]};
    end
    sum      = {1'b0, cnt_reg} + {6'd0, inc};
    cnt_next = sum[8] ? 8'hFF : sum[7:0];
    if (clear) begin
      cnt_next = 8'd0;
    end
  end

  // Completion counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign led1     = led_vec[0];
  assign led2     = led_vec[1];
  assign led3     = led_vec[2];
  assign led4     = led_vec[3];
  assign led_done = &done_vec;
  assign done_cnt = cnt_reg;

endmodule

// File: tb/tb_core_led_scheduler.sv
// Directed bench for core_led_scheduler with a 4-cycle blink half-period.
module tb_core_led_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] core_start;
  logic [3:0] core_done;
  logic       clear;
  logic       led1, led2, led3, led4;
  logic       led_done;
  logic [7:0] done_cnt;

  int pass_cnt;
  int total_cnt;
  int edges;

  core_led_scheduler #(.BLINK_HALF(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_start (core_start),
    .core_done  (core_done),
    .clear      (clear),
    .led1       (led1),
    .led2       (led2),
    .led3       (led3),
    .led4       (led4),
    .led_done   (led_done),
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference blink phase: edges counted since reset release, phase = (edges/4) mod 2.
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  function automatic logic exp_phase();
    return logic'((edges / 4) % 2);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] leds();
    return {4'b0000, led4, led3, led2, led1};
  endfunction

  initial begin
    logic ph;
    bit   found;
    pass_cnt   = 0;
    total_cnt  = 0;
    rst        = 1'b1;
    core_start = 4'b0000;
    core_done  = 4'b0000;
    clear      = 1'b0;

    // Reset held for 2 cycles
    #2;
    chk("reset_leds", leds(), 8'h00);
    chk("reset_led_done", {7'd0, led_done}, 8'h00);
    chk("reset_cnt", done_cnt, 8'h00);
    tick();
    tick();
    rst = 1'b0;

    // 20 idle cycles: everything stays dark
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_leds", leds(), 8'h00);
      chk("idle_led_done", {7'd0, led_done}, 8'h00);
      chk("idle_cnt", done_cnt, 8'h00);
    end

    // Start core 0 for one cycle: led1 blinks, others dark
    core_start = 4'b0001;
    tick();
    core_start = 4'b0000;
    chk("run0_led", leds(), {7'd0, exp_phase()});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("run0_blink", leds(), {7'd0, exp_phase()});
    end

    // Done core 0: steady on, count 1
    core_done = 4'b0001;
    tick();
    core_done = 4'b0000;
    chk("done0_leds", leds(), 8'h01);
    chk("done0_cnt", done_cnt, 8'd1);
    chk("done0_led_done", {7'd0, led_done}, 8'h00);

    // Done strobe on a DONE core is ignored
    core_done = 4'b0001;
    tick();
    core_done = 4'b0000;
    chk("done_ignored_cnt", done_cnt, 8'd1);

    // Start all cores, then finish all on one cycle
    core_start = 4'b1111;
    tick();
    core_start = 4'b0000;
    ph = exp_phase();
    chk("all_run_leds", leds(), {4'd0, {4{ph}}});
    core_done = 4'b1111;
    tick();
    core_done = 4'b0000;
    chk("all_done_leds", leds(), 8'h0F);
    chk("all_done_led_done", {7'd0, led_done}, 8'h01);
    chk("all_done_cnt", done_cnt, 8'd5);

    // Restart core 2: led_done drops in the same cycle
    core_start = 4'b0100;
    tick();
    core_start = 4'b0000;
    chk("restart2_led_done", {7'd0, led_done}, 8'h00);
    chk("restart2_leds", leds(), {4'd0, 1'b1, exp_phase(), 2'b11});
    core_done = 4'b0100;
    tick();
    core_done = 4'b0000;
    chk("redone2_led_done", {7'd0, led_done}, 8'h01);
    chk("redone2_cnt", done_cnt, 8'd6);

    // Plain clear: all idle, count 0
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_leds", leds(), 8'h00);
    chk("clear_cnt", done_cnt, 8'd0);

    // Start+done together on IDLE core 0 -> RUN
    core_start = 4'b0001;
    core_done  = 4'b0001;
    tick();
    chk("sd_idle_led", leds(), {7'd0, exp_phase()});
    chk("sd_idle_cnt", done_cnt, 8'd0);
    // Start+done together on RUN core 0 -> DONE
    tick();
    core_start = 4'b0000;
    core_done  = 4'b0000;
    chk("sd_run_led", leds(), 8'h01);
    chk("sd_run_cnt", done_cnt, 8'd1);

    // Clear with done=1111 on RUN cores: clear wins
    core_start = 4'b1111;
    tick();
    core_start = 4'b0000;
    clear      = 1'b1;
    core_done  = 4'b1111;
    tick();
    clear      = 1'b0;
    core_done  = 4'b0000;
    chk("clr_done_leds", leds(), 8'h00);
    chk("clr_done_cnt", done_cnt, 8'd0);
    chk("clr_done_led_done", {7'd0, led_done}, 8'h00);

    // 260 completions, 4 per round: saturates at 255 on the round crossing 256
    for (int r = 1; r <= 65; r++) begin
      core_start = 4'b1111;
      tick();
      core_start = 4'b0000;
      core_done  = 4'b1111;
      tick();
      core_done  = 4'b0000;
      if (r == 1)  chk("sat_r1", done_cnt, 8'd4);
      if (r == 63) chk("sat_r63", done_cnt, 8'd252);
      if (r == 64) chk("sat_r64", done_cnt, 8'd255);
      if (r == 65) chk("sat_r65", done_cnt, 8'd255);
    end
    chk("sat_leds", leds(), 8'h0F);

    // Get all cores running and wait for the lit blink phase
    core_start = 4'b1111;
    tick();
    core_start = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (exp_phase() == 1'b1) found = 1'b1;
      else tick();
    end
    chk("wait_phase_high", {7'd0, found}, 8'h01);
    chk("prerst_leds", leds(), 8'h0F);

    // Reset pulsed between edges: outputs drop without a clock
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_leds", leds(), 8'h00);
    chk("midrst_led_done", {7'd0, led_done}, 8'h00);
    chk("midrst_cnt", done_cnt, 8'd0);
    tick();
    tick();
    rst        = 1'b0;
    core_start = 4'b0001;

    // After release: core 0 starts on edge 1; low through edge 3, high edges 4..7, low at 8
    for (int j = 1; j <= 8; j++) begin
      tick();
      core_start = 4'b0000;
      chk($sformatf("postrst_blink_e%0d", j), leds(), (j >= 4 && j < 8) ? 8'h01 : 8'h00);
    end
    chk("postrst_cnt", done_cnt, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/core_led_scheduler.md
CORE_LED_SCHEDULER -- requirements
Module: core_led_scheduler

Interface
REQ-001 Parameter BLINK_HALF, default 25000000; clk cycles per blink half-period; legal range 2..2^26-1.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 core_start  input  4  per-core job-start strobe; bit i is core i.
REQ-005 core_done  input  4  per-core job-complete strobe; bit i is core i.
REQ-006 clear  input  1  synchronous clear of all core states and the completion count.
REQ-007 led1, led2, led3, led4  output  1 each  status LEDs for cores 0..3.
REQ-008 led_done  output  1  all four cores in DONE.
REQ-009 done_cnt  output  8  saturating count of completed jobs since reset or clear.

Function
REQ-010 Prescaler: free-running counter 0..BLINK_HALF-1; increments every cycle; wraps to 0 after BLINK_HALF-1.
REQ-011 Blink: the blink phase bit toggles on each wrap cycle, so phase is 0 for BLINK_HALF cycles, then 1 for BLINK_HALF cycles.
REQ-012 Neither clear nor any core input affects the prescaler or the blink phase.
REQ-013 Each core has an independent 3-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: core_start[i]=1 -> RUN; core_done[i] is ignored, including when asserted together with start.
REQ-015 RUN: core_done[i]=1 -> DONE; core_start[i] is ignored; start and done together -> DONE.
REQ-016 DONE: core_start[i]=1 -> RUN (next job); otherwise the FSM holds DONE; core_done[i] is ignored.
REQ-017 clear=1 forces all four FSMs to IDLE on that edge and overrides every start/done input in the same cycle.
REQ-018 LED decode is combinational from registered state:
- IDLE = 0.
- RUN = blink phase.
- DONE = 1.
REQ-019 Latency: an LED reflects a start/done event sampled at edge N immediately after edge N; no further delay.
REQ-020 led_done = 1 exactly when all four FSMs are in DONE; it drops in the same cycle any core leaves DONE.
REQ-021 done_cnt increments by the number of RUN->DONE transitions (0..4) on each edge.
REQ-022 done_cnt saturates at 255 and never wraps, including when a multi-core increment would overflow.
REQ-023 clear sets done_cnt to 0; on a cycle with clear plus transitions, the result is 0.
REQ-024 Strobes are level-sampled; a strobe held high for several cycles behaves as repeated single-cycle strobes under REQ-014..016.

Reset
REQ-025 Asserting rst, asynchronously and independent of clk:
- all FSMs -> IDLE;
- prescaler = 0;
- blink phase = 0;
- done_cnt = 0;
- led1..led4 = 0;
- led_done = 0.
REQ-026 Reset asserted mid-job drops all LEDs to 0 without waiting for a clock edge.
REQ-027 First prescaler increment occurs on the first rising edge after rst deasserts.

Verification (BLINK_HALF=4)
REQ-028 Bench shall cover these directed scenarios:
- Reset 2 cycles, then 20 idle cycles -> led1..4=0, led_done=0, done_cnt=0 throughout.
- core_start=0001 for 1 cycle -> led1 follows blink: low 4 cycles, high 4 cycles, repeating; led2..4 stay 0.
- core_done=0001 one cycle later -> led1=1 steady, done_cnt=1.
- Start all cores, then done=1111 on one cycle -> led1..4=1, led_done=1, done_cnt += 4.
- Start and done together on an IDLE core -> RUN; on a RUN core -> DONE.
- clear together with done=1111 on RUN cores -> all IDLE, LEDs=0, done_cnt=0.
- Run 260 job completions -> done_cnt holds 255.
- rst pulsed mid-RUN between clock edges -> LEDs go 0 immediately.
- After rst deasserts -> blink resumes with a full 4-cycle low phase.
